// File: rtl/saw_osc_ctrl.sv
// Sawtooth oscillator controller: looks up a divider period from an external
// registered ROM per note request, then steps an unsigned ramp every `period` sample ticks.
module saw_osc_ctrl #(
  parameter int          SAW_BITS   = 8,
  parameter logic [15:0] PERIOD_RST = 16'd1804
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                note_valid,
  input  logic [6:0]          note,
  output logic                note_ready,
  input  logic                gate,
  input  logic                sample_tick,
  output logic                rom_en,
  output logic [6:0]          rom_addr,
  input  logic [15:0]         rom_data,
  output logic [SAW_BITS-1:0] saw_out,
  output logic [15:0]         period,
  output logic                active,
  output logic                note_err
);

  typedef enum logic [1:0] {IDLE, REQ, CAP, RUN} state_t;

  state_t                state_q, state_d;
  logic [6:0]            rom_addr_q, rom_addr_d;
  logic [15:0]           period_q, period_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [SAW_BITS-1:0]   saw_q, saw_d;
  logic                  note_err_q, note_err_d;
  logic                  accept;

  assign note_ready = (state_q == IDLE) || (state_q == RUN);
  assign accept     = note_valid && note_ready;
  assign rom_en     = (state_q == REQ);
  assign rom_addr   = rom_addr_q;
  assign saw_out    = saw_q;
  assign period     = period_q;
  assign active     = (state_q == RUN);
  assign note_err   = note_err_q;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    saw_d      = saw_q;
    note_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rom_addr_d = note;
          state_d    = REQ;
        end
      end
      REQ: state_d = CAP;
      CAP: begin
        period_d = rom_data;
        if (rom_data == 16'd0) begin
          note_err_d = 1'b1;
          state_d    = IDLE;
        end else if (gate) begin
          cnt_d   = 16'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A new note outranks gate release; the ramp freezes while retuning.
        if (accept) begin
          rom_addr_d = note;
          state_d    = REQ;
        end else if (!gate) begin
          saw_d   = '0;
          cnt_d   = 16'd0;
          state_d = IDLE;
        end else if (sample_tick) begin
          if (cnt_q == period_q - 16'd1) begin
            cnt_d = 16'd0;
            saw_d = saw_q + SAW_BITS'(1);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_addr_q <= 7'd0;
      period_q   <= PERIOD_RST;
      cnt_q      <= 16'd0;
      saw_q      <= '0;
      note_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      saw_q      <= saw_d;
      note_err_q <= note_err_d;
    end
  end

endmodule

// File: doc/saw_osc_ctrl.md
SAW_OSC_CTRL -- requirements
Module: saw_osc_ctrl

Interface
REQ-001 Parameter SAW_BITS, default 8, width of the sawtooth ramp output.
REQ-002 Parameter PERIOD_RST, default 1804, period register value after reset.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 note_valid  in  1  note request strobe.
REQ-006 note  in  7  note index to look up in the saw frequency ROM.
REQ-007 note_ready  out  1  high when a note request is accepted this cycle.
REQ-008 gate  in  1  note-on level; low silences the oscillator.
REQ-009 sample_tick  in  1  one-cycle sample-rate enable.
REQ-010 rom_en  out  1  ROM read enable to the saw frequency ROM.
REQ-011 rom_addr  out  7  ROM address.
REQ-012 rom_data  in  16  ROM registered output, valid the cycle after rom_en=1.
REQ-013 saw_out  out  SAW_BITS  unsigned ramp sample.
REQ-014 period  out  16  currently loaded divider period.
REQ-015 active  out  1  high while state is RUN.
REQ-016 note_err  out  1  one-cycle pulse when the looked-up period is 0.

Function
REQ-017 FSM states: IDLE, REQ, CAP, RUN.
REQ-018 Handshake: accept when note_valid=1 and note_ready=1; note_ready=1 in IDLE and RUN, 0 in REQ and CAP.
REQ-019 Accept in cycle t: latch note, go to REQ; in REQ (cycle t+1), rom_en=1 and rom_addr=latched note; go to CAP.
REQ-020 In CAP (cycle t+2): rom_en=0; period <= rom_data at the end of the cycle.
REQ-021 CAP exit rules:
  - rom_data=0: note_err=1 for 1 cycle, go to IDLE.
  - rom_data!=0 and gate=1: go to RUN.
  - rom_data!=0 and gate=0: go to IDLE.
REQ-022 Lookup latency: accept at t -> active=1 at t+3 at the earliest.
REQ-023 rom_en is 1 only in REQ. rom_addr holds its last value otherwise.
REQ-024 Divider counter cnt is 16 bit and is cleared on every entry to RUN.
REQ-025 In RUN, on sample_tick=1:
  - cnt==period-1: cnt<=0 and saw_out<=saw_out+1.
  - otherwise: cnt<=cnt+1.
REQ-026 saw_out wraps modulo 2^SAW_BITS (max -> 0). period=1 steps saw_out on every tick.
REQ-027 sample_tick is ignored outside RUN; saw_out holds during REQ/CAP retune.
REQ-028 RUN with gate=0 and no accept: go to IDLE, saw_out<=0, cnt<=0.
REQ-029 RUN with an accepted note: go to REQ; this takes priority over gate=0 in the same cycle.
REQ-030 IDLE with gate=1 and no pending request: remain IDLE; RUN is entered only via CAP.

Reset
REQ-031 rst=1 on a clock edge sets:
  - state=IDLE, saw_out=0, cnt=0, period=PERIOD_RST.
  - rom_en=0, rom_addr=0, note_err=0, active=0.
  - note_ready=1 in the cycle after reset.
REQ-032 rst overrides all other inputs, including mid-lookup (REQ/CAP) and RUN. A request pending at reset is discarded; no ROM read completes into period.

Verification
REQ-033 Lookup timing: reset, gate=1, note=69 accepted at t, ROM returns 1804 -> rom_en=1 and rom_addr=69 only at t+1; period=1804 and active=1 at t+3.
REQ-034 Ramp stepping: period=100, sample_tick every cycle -> saw_out increments exactly every 100 ticks; 255 -> 0 wrap with SAW_BITS=8.
REQ-035 Invalid note: note=5, ROM returns 0 -> note_err pulse of 1 cycle; state IDLE; saw_out=0; active=0.
REQ-036 Retune in RUN: note 12 (48537) accepted -> saw_out frozen for 3 cycles; cnt cleared; period=48537 on re-entering RUN.
REQ-037 Gate release and same-cycle request: gate->0 in RUN -> next cycle active=0, saw_out=0; gate=0 with note_valid in the same cycle -> REQ taken.
REQ-038 Reset mid-lookup: rst in CAP -> period=1804, state IDLE, rom_en=0, no note_err.
